// File: rtl/prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : prog_sequencer
// Purpose  : Start/done run controller that selects a program, loads its entry
//            PC into the core, runs it until halt or watchdog, then reports done.
// Revision : 1.0
// ============================================================================
module prog_sequencer #(
  parameter int PC_W    = 10,
  parameter int P0_BASE = 0,
  parameter int P1_BASE = 128,
  parameter int P2_BASE = 256,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  output logic             done,
  input  logic             core_halt,
  output logic             core_run,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_load_val,
  input  logic             sel_en,
  input  logic [1:0]       sel,
  output logic [1:0]       prog_id,
  output logic [CNT_W-1:0] cycle_count,
  output logic             timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0]       LAST_ID      = 2'd2;
  localparam logic [1:0]       INVALID_SEL  = 2'd3;

  state_t           state_q, state_d;
  logic             start_q;
  logic             start_rise;
  logic [1:0]       prog_id_q, prog_id_d;
  logic [1:0]       next_id_q, next_id_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       successor_id;

  assign start_rise   = start & ~start_q;
  assign successor_id = (prog_id_q == LAST_ID) ? 2'd0 : prog_id_q + 2'd1;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q       <= S_IDLE;
      start_q       <= 1'b0;
      prog_id_q     <= 2'd0;
      next_id_q     <= 2'd0;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_q       <= start;
      prog_id_q     <= prog_id_d;
      next_id_q     <= next_id_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    prog_id_d     = prog_id_q;
    next_id_d     = next_id_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_rise) begin
          state_d       = S_LOAD;
          prog_id_d     = (sel_en && (sel != INVALID_SEL)) ? sel : next_id_q;
          cycle_count_d = '0;
          timeout_d     = 1'b0;
        end
      end
      S_LOAD: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        cycle_count_d = cycle_count_q + CNT_W'(1);
        // Halt takes priority over a watchdog expiring in the same cycle.
        if (core_halt) begin
          state_d   = S_DONE;
          next_id_d = successor_id;
        end else if (cycle_count_q == TIMEOUT_LAST) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
          next_id_d = successor_id;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    done        = (state_q == S_DONE);
    core_run    = (state_q == S_RUN);
    pc_load     = (state_q == S_LOAD);
    pc_load_val = '0;
    if (state_q == S_LOAD) begin
      case (prog_id_q)
        2'd0:    pc_load_val = PC_W'(P0_BASE);
        2'd1:    pc_load_val = PC_W'(P1_BASE);
        2'd2:    pc_load_val = PC_W'(P2_BASE);
        default: pc_load_val = '0;
      endcase
    end
  end

  assign prog_id     = prog_id_q;
  assign cycle_count = cycle_count_q;
  assign timeout     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_sequencer.sv
`default_nettype none
// Directed bench for prog_sequencer: default-parameter instance plus a
// short-watchdog instance (TIMEOUT=8).
module tb_prog_sequencer;

  localparam int PC_W  = 10;
  localparam int CNT_W = 16;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic             reset;
  logic             start, core_halt, sel_en;
  logic [1:0]       sel;
  logic             done, core_run, pc_load, timeout;
  logic [PC_W-1:0]  pc_load_val;
  logic [1:0]       prog_id;
  logic [CNT_W-1:0] cycle_count;

  logic             wd_start, wd_core_halt;
  logic             wd_done, wd_core_run, wd_pc_load, wd_timeout;
  logic [PC_W-1:0]  wd_pc_load_val;
  logic [1:0]       wd_prog_id;
  logic [CNT_W-1:0] wd_cycle_count;

  prog_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .reset(reset), .start(start), .done(done),
    .core_halt(core_halt), .core_run(core_run), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .sel_en(sel_en), .sel(sel),
    .prog_id(prog_id), .cycle_count(cycle_count), .timeout(timeout)
  );

  prog_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W), .TIMEOUT(8)) dut_wd (
    .CLK(CLK), .reset(reset), .start(wd_start), .done(wd_done),
    .core_halt(wd_core_halt), .core_run(wd_core_run), .pc_load(wd_pc_load),
    .pc_load_val(wd_pc_load_val), .sel_en(1'b0), .sel(2'd0),
    .prog_id(wd_prog_id), .cycle_count(wd_cycle_count), .timeout(wd_timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  // One full start -> LOAD -> RUN -> halt -> DONE transaction on the main instance.
  task automatic run_prog(input int run_cycles, input logic en, input logic [1:0] s,
                          input logic [PC_W-1:0] exp_pc, input logic [1:0] exp_id);
    int not_running;
    not_running = 0;
    sel_en = en;
    sel    = s;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    sel_en = 1'b0;
    sel    = 2'd0;
    check("load_strobe", pc_load, 1);
    check("load_pc", pc_load_val, exp_pc);
    check("load_no_run", core_run, 0);
    tick();
    for (int i = 1; i <= run_cycles; i++) begin
      if (core_run !== 1'b1 || done !== 1'b0) not_running++;
      core_halt = (i == run_cycles);
      tick();
    end
    core_halt = 1'b0;
    check("run_enable", not_running, 0);
    check("done", done, 1);
    check("done_core_run", core_run, 0);
    check("prog_id", prog_id, exp_id);
    check("cycles", cycle_count, run_cycles);
    check("timeout_clear", timeout, 0);
    check("pc_val_idle", pc_load_val, 0);
  endtask

  initial begin
    int runs;
    int loads;
    int not_running;

    reset = 1'b1; start = 1'b0; core_halt = 1'b0; sel_en = 1'b0; sel = 2'd0;
    wd_start = 1'b0; wd_core_halt = 1'b0;
    repeat (3) tick();
    check("rst_done", done, 0);
    check("rst_core_run", core_run, 0);
    check("rst_pc_load", pc_load, 0);
    check("rst_pc_val", pc_load_val, 0);
    check("rst_prog_id", prog_id, 0);
    check("rst_cycles", cycle_count, 0);
    check("rst_timeout", timeout, 0);
    reset = 1'b0;
    tick();

    // Basic run: halt on the 20th RUN cycle; done must then hold.
    run_prog(20, 1'b0, 2'd0, 10'd0, 2'd0);
    repeat (2) tick();
    check("done_hold", done, 1);
    check("done_hold_cycles", cycle_count, 20);

    // Rotation 1 -> 2 -> wrap to 0.
    run_prog(3, 1'b0, 2'd0, 10'd128, 2'd1);
    run_prog(5, 1'b0, 2'd0, 10'd256, 2'd2);
    run_prog(4, 1'b0, 2'd0, 10'd0,   2'd0);

    // Watchdog instance: no halt -> forced done after exactly 8 RUN cycles.
    runs = 0;
    wd_start = 1'b1;
    tick();
    wd_start = 1'b0;
    check("wd_load", wd_pc_load, 1);
    tick();
    for (int i = 0; i < 20 && !wd_done; i++) begin
      if (wd_core_run) runs++;
      tick();
    end
    check("wd_done", wd_done, 1);
    check("wd_run_cycles", runs, 8);
    check("wd_cycles", wd_cycle_count, 8);
    check("wd_timeout", wd_timeout, 1);
    check("wd_prog_id", wd_prog_id, 0);

    // Halt coinciding with the 8th RUN cycle: halt wins.
    wd_start = 1'b1;
    tick();
    wd_start = 1'b0;
    check("wd2_load_pc", wd_pc_load_val, 128);
    tick();
    for (int i = 1; i <= 8; i++) begin
      wd_core_halt = (i == 8);
      tick();
    end
    wd_core_halt = 1'b0;
    check("wd2_done", wd_done, 1);
    check("wd2_cycles", wd_cycle_count, 8);
    check("wd2_timeout", wd_timeout, 0);

    // start held 5 edges, then re-pulsed during RUN: one LOAD only.
    loads = 0;
    not_running = 0;
    start = 1'b1;
    tick();
    check("hold_load", pc_load, 1);
    check("hold_load_pc", pc_load_val, 128);
    tick();
    for (int i = 1; i <= 12; i++) begin
      if (pc_load) loads++;
      if (!core_run) not_running++;
      start     = (i <= 3) || (i == 7);
      core_halt = (i == 12);
      tick();
    end
    start = 1'b0;
    core_halt = 1'b0;
    check("hold_extra_loads", loads, 0);
    check("hold_run_steady", not_running, 0);
    check("hold_done", done, 1);
    check("hold_cycles", cycle_count, 12);
    check("hold_prog_id", prog_id, 1);

    // Selection override: sel=3 ignored (next_id=2), then sel=2, then rotation resumes at 0.
    run_prog(2, 1'b1, 2'd3, 10'd256, 2'd2);
    run_prog(2, 1'b1, 2'd2, 10'd256, 2'd2);
    run_prog(2, 1'b0, 2'd0, 10'd0,   2'd0);

    // Reset in the middle of a run aborts it.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("abort_load_pc", pc_load_val, 128);
    repeat (6) tick();
    check("abort_pre_running", core_run, 1);
    reset = 1'b1;
    tick();
    check("abort_core_run", core_run, 0);
    check("abort_done", done, 0);
    check("abort_cycles", cycle_count, 0);
    check("abort_prog_id", prog_id, 0);
    reset = 1'b0;
    tick();
    run_prog(7, 1'b0, 2'd0, 10'd0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Run controller between the bench-facing start/done handshake and the processor core.
- Each start pulse selects the next program (0→1→2→0), loads that program's entry PC into the core and releases the core to fetch.
- Waits for the core's halt indication, then raises done and holds it until the next start.
- Also provides a cycle counter and a watchdog timeout, so a hung program still returns done.

Parameters:
- PC_W, 10, width of program counter / entry address.
- P0_BASE, 0, entry PC of program 0 (Hamming encode).
- P1_BASE, 128, entry PC of program 1 (Hamming decode/correct).
- P2_BASE, 256, entry PC of program 2 (pattern count).
- CNT_W, 16, width of run-cycle counter.
- TIMEOUT, 65535, RUN cycles before forced termination; must be ≤ 2^CNT_W-1.

Ports:
- CLK, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, request from bench; level, acted on at rising edge only.
- done, output, 1, program complete; high in DONE state only.
- core_halt, input, 1, core executed halt; sampled only in RUN.
- core_run, output, 1, fetch/execute enable to core; high in RUN only.
- pc_load, output, 1, one-cycle strobe; core PC <= pc_load_val.
- pc_load_val, output, PC_W, entry address of the selected program.
- sel_en, input, 1, override program selection at start edge.
- sel, input, 2, program index used when sel_en=1; value 3 is invalid.
- prog_id, output, 2, index of the current or last program.
- cycle_count, output, CNT_W, RUN cycles of the current or last program.
- timeout, output, 1, last program ended by watchdog rather than halt.

Behaviour:
- Start edge detect:
  - start_q is a register of start; start_rise = start & ~start_q.
  - start_q is cleared by reset, so start held high through reset produces one start_rise on the first cycle after reset.
- States: IDLE, LOAD, RUN, DONE. Outputs are Moore, decoded from registered state.
- Reset:
  - state=IDLE, prog_id=0, next_id=0, cycle_count=0, timeout=0.
  - done=0, core_run=0, pc_load=0, pc_load_val=0.
  - Reset mid-RUN aborts the program immediately; core_run drops the next cycle.
- IDLE or DONE, start_rise:
  - Go to LOAD.
  - prog_id <= (sel_en && sel!=3) ? sel : next_id. sel==3 with sel_en=1 is ignored (next_id used).
  - cycle_count <= 0, timeout <= 0.
- LOAD (exactly 1 cycle):
  - pc_load=1; pc_load_val = P{prog_id}_BASE; core_run=0; done=0.
  - Unconditionally go to RUN.
  - core_halt is ignored.
- RUN:
  - core_run=1; cycle_count increments by 1 every RUN cycle, including the cycle halt is seen.
  - core_halt=1 → DONE, timeout stays 0.
  - Else if cycle_count == TIMEOUT-1 (the TIMEOUT-th RUN cycle) → DONE, timeout <= 1.
  - If halt and the watchdog fire in the same cycle, halt wins (timeout=0).
- DONE:
  - done=1, core_run=0; cycle_count and timeout hold.
  - On entry, next_id <= (prog_id==2) ? 0 : prog_id+1.
  - Stays in DONE until start_rise, then proceeds as from IDLE.
- start_rise in LOAD or RUN is ignored and not queued.
- Latency:
  - start_rise at edge N → pc_load high cycle N+1 → core_run high from N+2.
  - core_halt sampled at edge M → done=1 and core_run=0 from M+1.
- pc_load_val is 0 outside LOAD.
- cycle_count never wraps; the bound is guaranteed by TIMEOUT.

Test Plan:
- Reset, start pulsed 1 cycle, core_halt after 20 RUN cycles → pc_load one cycle with value 0, done=1, prog_id=0, cycle_count=20, timeout=0.
- Three consecutive start/halt runs → pc_load_val 0, 128, 256 in order; a 4th start gives 0 again (wrap).
- TIMEOUT=8, core_halt never asserted → done after exactly 8 RUN cycles, cycle_count=8, timeout=1. With halt on the 8th cycle instead → timeout=0.
- start held high 5 cycles; start re-pulsed during RUN → exactly one LOAD, no restart, program completes normally.
- sel_en=1, sel=2 → pc_load_val=256, next program is 0. sel_en=1, sel=3 → next_id used.
- reset asserted mid-RUN → core_run=0 and done=0 the next cycle; next start runs program 0 with cycle_count restarted from 0.
